// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the memory request arbiter.
// Round-robin pick and ID width calculation.
package arbiter_pkg;

    localparam int unsigned MAX_REQ = 32;

    function automatic int unsigned id_width(input int unsigned n);
        id_width = (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        n
    );
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && valid[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order FIFO of issuer IDs for outstanding memory requests.
// Wrap-bit pointers; head is read straight from storage.
module id_fifo
    import arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Advance pointers on push/pop; reset empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Store the pushed ID; storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request channel,
// with in-order response routing back to each issuer.
module mem_req_arbiter
    import arbiter_pkg::*;
#(
    parameter int REQ_NUM   = 2,
    parameter int DATA_SIZE = 32,
    parameter int ID_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         kill,
    input  logic [REQ_NUM-1:0]           req_valid,
    output logic [REQ_NUM-1:0]           req_ready,
    input  logic [REQ_NUM*DATA_SIZE-1:0] req_data,
    output logic [REQ_NUM-1:0]           resp_valid,
    output logic [DATA_SIZE-1:0]         resp_data,
    output logic                         mreq_valid,
    input  logic                         mreq_ready,
    output logic [DATA_SIZE-1:0]         mreq_data,
    input  logic                         mresp_valid,
    input  logic [DATA_SIZE-1:0]         mresp_data,
    output logic                         err_resp
);

    localparam int IDW = id_width(REQ_NUM);

    logic [IDW-1:0]     rr_ptr;
    logic               lock;
    logic [IDW-1:0]     locked_id;
    logic [IDW-1:0]     grant;
    logic [IDW-1:0]     rr_grant;
    logic [MAX_REQ-1:0] valid_ext;
    logic               hs;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [IDW-1:0]     head_id;

    // Widen requester valids to the helper's fixed width.
    always_comb begin
        valid_ext               = '0;
        valid_ext[REQ_NUM-1:0]  = req_valid;
    end

    assign rr_grant   = IDW'(rr_pick(valid_ext, 32'(rr_ptr), REQ_NUM));
    assign grant      = lock ? locked_id : rr_grant;
    assign mreq_valid = req_valid[grant] && !fifo_full && !kill && !reset;
    assign mreq_data  = req_data[grant*DATA_SIZE +: DATA_SIZE];
    assign hs         = mreq_valid && mreq_ready;
    assign pop        = mresp_valid && !fifo_empty;
    assign resp_data  = mresp_data;

    // One-hot accept for the granted requester on handshake.
    always_comb begin
        req_ready        = '0;
        req_ready[grant] = hs;
    end

    // One-hot response strobe to the oldest outstanding issuer.
    always_comb begin
        resp_valid          = '0;
        resp_valid[head_id] = pop;
    end

    // Round-robin pointer, grant lock and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            lock      <= 1'b0;
            locked_id <= '0;
            err_resp  <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr <= (grant == IDW'(REQ_NUM - 1)) ? '0 : grant + 1'b1;
            end
            if (kill) begin
                lock <= 1'b0;
            end else if (mreq_valid && !mreq_ready) begin
                lock      <= 1'b1;
                locked_id <= grant;
            end else if (hs) begin
                lock <= 1'b0;
            end
            if (mresp_valid && fifo_empty) err_resp <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (ID_DEPTH),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hs),
        .pop   (pop),
        .din   (grant),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_id)
    );

endmodule
